linebuf_ctrl: RTL and testbench

LINEBUF_CTRL -- requirements
Module: linebuf_ctrl

---
 rtl/linebuf_ctrl.sv | 139 +++++++++++++
 tb/tb_linebuf_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/linebuf_ctrl.sv
// Line-buffer write controller: tracks column/row/bank for a TAPS-high window
// and measures line width and frame height from the de/hsync/vsync status bus.
module linebuf_ctrl #(
    parameter int ADDR_W = 11,
    parameter int MAX_W  = 1920,
    parameter int TAPS   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        stat_in,
    output logic              wr_en,
    output logic [ADDR_W-1:0] addr,
    output logic [2:0]        bank_sel,
    output logic [ADDR_W-1:0] row,
    output logic              win_valid,
    output logic [ADDR_W-1:0] width,
    output logic [ADDR_W-1:0] height,
    output logic              ovf,
    output logic [2:0]        stat_o
);

    localparam logic [1:0] VBLANK = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] HBLANK = 2'd2;

    // Pixel count needs one extra bit so a full line (MAX_W) is distinguishable
    // from a line that has only reached column MAX_W-1.
    localparam int              CNT_W     = ADDR_W + 1;
    localparam logic [CNT_W-1:0] MAX_PIX  = CNT_W'(MAX_W);
    localparam logic [2:0]      LAST_BANK = 3'(TAPS - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  pix_q, pix_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [2:0]        bank_q, bank_d;
    logic [2:0]        lines_q, lines_d;
    logic [ADDR_W-1:0] width_q, width_d;
    logic [ADDR_W-1:0] height_q, height_d;
    logic              ovf_q, ovf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              win_q, win_d;
    logic [2:0]        stat_q, stat_d;

    logic de, vs, vs_rise, pix_room;

    assign de       = stat_in[0];
    assign vs       = stat_in[2];
    assign vs_rise  = vs & ~stat_q[2];
    assign pix_room = (pix_q < MAX_PIX);

    always_comb begin
        state_d  = state_q;
        pix_d    = pix_q;
        row_d    = row_q;
        bank_d   = bank_q;
        lines_d  = lines_q;
        width_d  = width_q;
        height_d = height_q;
        ovf_d    = ovf_q;
        addr_d   = addr_q;
        wr_en_d  = 1'b0;
        win_d    = 1'b0;
        stat_d   = stat_in;

        if (vs) begin
            // vsync overrides de entirely; only its rising edge restarts the frame
            state_d = VBLANK;
            if (vs_rise) begin
                height_d = row_q;
                row_d    = '0;
                bank_d   = '0;
                pix_d    = '0;
                lines_d  = '0;
                addr_d   = '0;
            end
        end else if (de) begin
            state_d = ACTIVE;
            if (pix_room) begin
                wr_en_d = 1'b1;
                addr_d  = pix_q[ADDR_W-1:0];
                pix_d   = pix_q + CNT_W'(1);
                win_d   = (lines_q == LAST_BANK);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (state_q == ACTIVE) begin
            state_d = HBLANK;
            width_d = pix_q[ADDR_W-1:0];
            pix_d   = '0;
            row_d   = row_q + ADDR_W'(1);
            bank_d  = (bank_q == LAST_BANK) ? 3'd0 : bank_q + 3'd1;
            if (lines_q != LAST_BANK) begin
                lines_d = lines_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= VBLANK;
            pix_q    <= '0;
            row_q    <= '0;
            bank_q   <= '0;
            lines_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            ovf_q    <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            win_q    <= 1'b0;
            stat_q   <= '0;
        end else begin
            state_q  <= state_d;
            pix_q    <= pix_d;
            row_q    <= row_d;
            bank_q   <= bank_d;
            lines_q  <= lines_d;
            width_q  <= width_d;
            height_q <= height_d;
            ovf_q    <= ovf_d;
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            win_q    <= win_d;
            stat_q   <= stat_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign addr      = addr_q;
    assign bank_sel  = bank_q;
    assign row       = row_q;
    assign win_valid = win_q;
    assign width     = width_q;
    assign height    = height_q;
    assign ovf       = ovf_q;
    assign stat_o    = stat_q;

endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl: directed line/frame scenarios with
// literal expectations, then random status traffic against a frame-level model.
module tb_linebuf_ctrl;

    localparam int ADDR_W = 11;
    localparam int MAX_W  = 16;
    localparam int TAPS   = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        stat_in = 3'b000;
    logic              wr_en;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        bank_sel;
    logic [ADDR_W-1:0] row;
    logic              win_valid;
    logic [ADDR_W-1:0] width;
    logic [ADDR_W-1:0] height;
    logic              ovf;
    logic [2:0]        stat_o;

    linebuf_ctrl #(.ADDR_W(ADDR_W), .MAX_W(MAX_W), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .stat_in(stat_in), .wr_en(wr_en), .addr(addr),
        .bank_sel(bank_sel), .row(row), .win_valid(win_valid), .width(width),
        .height(height), .ovf(ovf), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a line is open iff the previous sample was an accepted
    // de; bank and row follow from the count of completed lines in the frame.
    int       m_lines, m_pix, m_width, m_height, m_addr;
    bit       m_ovf, m_wr, m_win, m_prev_vs, m_prev_acc;
    logic [2:0] m_stat;
    bit       s_de, s_vs;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lines = 0; m_pix = 0; m_width = 0; m_height = 0; m_addr = 0;
            m_ovf = 0; m_wr = 0; m_win = 0; m_prev_vs = 0; m_prev_acc = 0;
            m_stat = 3'b000;
        end else begin
            s_de = stat_in[0];
            s_vs = stat_in[2];
            m_wr = 0;
            m_win = 0;
            if (s_vs && !m_prev_vs) begin
                m_height = m_lines % (1 << ADDR_W);
                m_lines  = 0;
                m_pix    = 0;
                m_addr   = 0;
            end else if (!s_vs && s_de) begin
                if (m_pix < MAX_W) begin
                    m_wr   = 1;
                    m_addr = m_pix;
                    m_win  = (m_lines >= TAPS - 1);
                    m_pix  = m_pix + 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (!s_vs && !s_de && m_prev_acc) begin
                m_width = m_pix;
                m_pix   = 0;
                m_lines = m_lines + 1;
            end
            m_prev_acc = !s_vs && s_de;
            m_prev_vs  = s_vs;
            m_stat     = stat_in;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_wr_en",     32'(wr_en),     32'(m_wr));
            chk("m_addr",      32'(addr),      32'(m_addr));
            chk("m_bank_sel",  32'(bank_sel),  32'(m_lines % TAPS));
            chk("m_row",       32'(row),       32'(m_lines % (1 << ADDR_W)));
            chk("m_win_valid", 32'(win_valid), 32'(m_win));
            chk("m_width",     32'(width),     32'(m_width));
            chk("m_height",    32'(height),    32'(m_height));
            chk("m_ovf",       32'(ovf),       32'(m_ovf));
            chk("m_stat_o",    32'(stat_o),    32'(m_stat));
            chk("bank_range",  32'(bank_sel <= 3'd4), 32'd1);
        end
    end

    task automatic cyc(input logic [2:0] s);
        @(negedge clk);
        stat_in = s;
        @(posedge clk);
        #1;
    endtask

    int bank_exp [6] = '{0, 1, 2, 3, 4, 0};
    int win_exp  [6] = '{0, 0, 0, 0, 1, 1};
    bit de_r, vs_r;

    initial begin
        #1 rst = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_bank",  32'(bank_sel), 32'd0);
        chk("rst_stat",  32'(stat_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Six 8-pixel lines separated by 4 idle cycles
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8; i++) begin
                cyc(3'b001);
                chk("line_addr",  32'(addr), 32'(i));
                chk("line_wr",    32'(wr_en), 32'd1);
                chk("line_bank",  32'(bank_sel), 32'(bank_exp[k]));
                chk("line_win",   32'(win_valid), 32'(win_exp[k]));
            end
            repeat (4) cyc(3'b000);
        end
        chk("six_width", 32'(width), 32'd8);
        chk("six_row",   32'(row), 32'd6);

        // vsync pulse closes the frame
        cyc(3'b100);
        chk("vs_height", 32'(height), 32'd6);
        chk("vs_row",    32'(row), 32'd0);
        cyc(3'b100);
        repeat (2) cyc(3'b000);
        for (int i = 0; i < 8; i++) begin
            cyc(3'b001);
            chk("nf_bank", 32'(bank_sel), 32'd0);
            chk("nf_win",  32'(win_valid), 32'd0);
        end
        repeat (4) cyc(3'b000);

        // 20-pixel line overflows a 16-pixel limit
        chk("ovf_pre", 32'(ovf), 32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(3'b001);
            chk("ov_addr", 32'(addr), (i < 16) ? 32'(i) : 32'd15);
            chk("ov_wr",   32'(wr_en), (i < 16) ? 32'd1 : 32'd0);
        end
        cyc(3'b000);
        chk("ov_width", 32'(width), 32'd16);
        chk("ov_flag",  32'(ovf), 32'd1);
        repeat (3) cyc(3'b000);
        chk("ov_sticky", 32'(ovf), 32'd1);

        // vsync rises while de is high at column 3
        repeat (3) cyc(3'b001);
        cyc(3'b101);
        chk("cut_wr",     32'(wr_en), 32'd0);
        chk("cut_width",  32'(width), 32'd16);
        chk("cut_row",    32'(row), 32'd0);
        chk("cut_height", 32'(height), 32'd2);
        repeat (3) cyc(3'b000);

        // Asynchronous reset mid-line at column 5
        repeat (5) cyc(3'b001);
        #2 rst = 1'b0;
        #1;
        chk("ar_wr",     32'(wr_en), 32'd0);
        chk("ar_addr",   32'(addr), 32'd0);
        chk("ar_bank",   32'(bank_sel), 32'd0);
        chk("ar_row",    32'(row), 32'd0);
        chk("ar_win",    32'(win_valid), 32'd0);
        chk("ar_width",  32'(width), 32'd0);
        chk("ar_height", 32'(height), 32'd0);
        chk("ar_ovf",    32'(ovf), 32'd0);
        chk("ar_stat",   32'(stat_o), 32'd0);
        repeat (2) cyc(3'b001);
        @(negedge clk);
        stat_in = 3'b000;
        rst = 1'b1;
        cyc(3'b001);
        chk("first_addr", 32'(addr), 32'd0);
        chk("first_bank", 32'(bank_sel), 32'd0);
        chk("first_wr",   32'(wr_en), 32'd1);
        repeat (3) cyc(3'b000);

        // Random status traffic with run-length de and occasional held vsync
        de_r = 1'b0;
        vs_r = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 7) == 0) de_r = ~de_r;
            if (vs_r) begin
                if ($urandom_range(0, 2) == 0) vs_r = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                vs_r = 1'b1;
            end
            cyc({vs_r, 1'($urandom_range(0, 1)), de_r});
        end

        @(posedge clk);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
